// File: rtl/microondas_pkg.sv
// rtl/microondas_pkg.sv - shared types, constants and helpers for the microwave timer
// Purpose: BCD digit width and limits, the packed MM:SS type, digit saturation helper.
// Ports: none (package).
package microondas_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;
  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

  // {min_tens, min_ones, sec_tens, sec_ones}
  typedef logic [4*BCD_W-1:0] mmss_t;

  // Clamp a raw nibble to the largest legal value for its digit position.
  function automatic logic [BCD_W-1:0] sat_digit(input logic [BCD_W-1:0] d,
                                                 input logic [BCD_W-1:0] max_val);
    return (d > max_val) ? max_val : d;
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_digit.sv
// rtl/countdown_timer_bcd_digit.sv - one BCD digit of the countdown with borrow out
// Purpose: registered BCD digit that loads or decrements; wraps 0 -> max_val.
// Ports:
//   clock, resetn      clock and asynchronous active-low reset
//   load, load_digit   synchronous load (takes priority over dec)
//   dec                decrement request for this cycle
//   max_val            value the digit wraps to on borrow
//   digit              registered digit value
//   borrow_out         combinational: dec requested while digit is 0
module bcd_digit_down
  import microondas_pkg::*;
(
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  input  logic             dec,
  input  logic [BCD_W-1:0] max_val,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  assign borrow_out = dec && (digit == '0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_digit;
    end else if (dec) begin
      digit <= (digit == '0) ? max_val : digit - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer_bcd.sv
// rtl/countdown_timer_bcd.sv - MM:SS BCD cooking-time countdown driven by mag_on
// Purpose: counts the loaded MM:SS time down once per second while mag_on is high;
//   timer_done flags 00:00 back to the magnetron control.
// Optional: define TIMER_ADD30_EN to add the add30 pulse input (+30 s, saturating at 99:59).
// Ports:
//   clock, resetn        clock and asynchronous active-low reset
//   clearn               synchronous active-low clear to 00:00
//   load, load_value     one-cycle capture of a BCD MM:SS value (sanitised)
//   mag_on               count enable
//   add30                (TIMER_ADD30_EN only) add 30 seconds
//   min_tens..sec_ones   current BCD digits
//   timer_done           registered, high exactly at 00:00
module countdown_timer_bcd
  import microondas_pkg::*;
#(
  parameter int CLK_PER_SEC = 100
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clearn,
  input  logic             load,
  input  logic [15:0]      load_value,
  input  logic             mag_on,
`ifdef TIMER_ADD30_EN
  input  logic             add30,
`endif
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             timer_done
);

  localparam int PRESC_W = $clog2(CLK_PER_SEC);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_SEC - 1);

  logic [PRESC_W-1:0] presc;
  logic               cnt_en;
  logic               tick;
  mmss_t              cur;
  mmss_t              sanitised;
  mmss_t              ld_val;
  logic               ld;
  logic               dec;
  logic               done_next;
  logic               b_so, b_st, b_mo, b_mt;

  assign cur    = {min_tens, min_ones, sec_tens, sec_ones};
  // Stopped at 00:00 the prescaler freezes, so ticks at 00:00 never happen.
  assign cnt_en = mag_on && !timer_done;
  assign tick   = cnt_en && (presc == PRESC_LAST);

  assign sanitised = {sat_digit(load_value[15:12], DIGIT_MAX),
                      sat_digit(load_value[11:8],  DIGIT_MAX),
                      sat_digit(load_value[7:4],   SEC_TENS_MAX),
                      sat_digit(load_value[3:0],   DIGIT_MAX)};

`ifdef TIMER_ADD30_EN
  mmss_t add30_val;
  // +30 s only touches sec_tens and carries into the minutes; sec_ones is unchanged.
  always_comb begin
    logic [BCD_W-1:0] st, mo, mt;
    logic             c_st, c_mo;
    add30_val = cur;
    st   = sec_tens + 4'd3;
    c_st = (st >= 4'd6);
    if (c_st) st = st - 4'd6;
    mo   = min_ones + {3'b0, c_st};
    c_mo = (mo == 4'd10);
    if (c_mo) mo = 4'd0;
    mt   = min_tens + {3'b0, c_mo};
    if (mt == 4'd10) begin
      add30_val = {DIGIT_MAX, DIGIT_MAX, SEC_TENS_MAX, DIGIT_MAX};
    end else begin
      add30_val = {mt, mo, st, sec_ones};
    end
  end
`endif

  // Priority mux: clear > load > add30 > tick > hold. Clear is a load of zero.
  always_comb begin
    ld        = 1'b0;
    ld_val    = cur;
    dec       = 1'b0;
    done_next = timer_done;
    if (!clearn) begin
      ld        = 1'b1;
      ld_val    = '0;
      done_next = 1'b1;
    end else if (load) begin
      ld        = 1'b1;
      ld_val    = sanitised;
      done_next = (sanitised == '0);
`ifdef TIMER_ADD30_EN
    end else if (add30) begin
      ld        = 1'b1;
      ld_val    = add30_val;
      done_next = (add30_val == '0);
`endif
    end else if (tick) begin
      dec       = 1'b1;
      done_next = (cur == 16'h0001);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      presc      <= '0;
      timer_done <= 1'b1;
    end else begin
      timer_done <= done_next;
      if (!clearn || load) begin
        presc <= '0;
      end else if (cnt_en) begin
        presc <= (presc == PRESC_LAST) ? '0 : presc + PRESC_W'(1);
      end
    end
  end

  bcd_digit_down u_sec_ones (
    .clock(clock), .resetn(resetn), .load(ld), .load_digit(ld_val[3:0]),
    .dec(dec), .max_val(DIGIT_MAX), .digit(sec_ones), .borrow_out(b_so)
  );

  bcd_digit_down u_sec_tens (
    .clock(clock), .resetn(resetn), .load(ld), .load_digit(ld_val[7:4]),
    .dec(b_so), .max_val(SEC_TENS_MAX), .digit(sec_tens), .borrow_out(b_st)
  );

  bcd_digit_down u_min_ones (
    .clock(clock), .resetn(resetn), .load(ld), .load_digit(ld_val[11:8]),
    .dec(b_st), .max_val(DIGIT_MAX), .digit(min_ones), .borrow_out(b_mo)
  );

  // Its borrow never fires: ticks stop once the count reaches 00:00.
  bcd_digit_down u_min_tens (
    .clock(clock), .resetn(resetn), .load(ld), .load_digit(ld_val[15:12]),
    .dec(b_mo), .max_val(DIGIT_MAX), .digit(min_tens), .borrow_out(b_mt)
  );

  logic unused_ok;
  assign unused_ok = b_mt;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// tb/tb_countdown_timer_bcd.sv - directed self-checking bench for countdown_timer_bcd
module tb_countdown_timer_bcd;

  logic        clock = 1'b0;
  logic        resetn;
  logic        clearn;
  logic        load;
  logic [15:0] load_value;
  logic        mag_on;
`ifdef TIMER_ADD30_EN
  logic        add30;
`endif
  logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
  logic        timer_done;
  logic [15:0] mmss;

  int checks = 0;
  int errors = 0;

  assign mmss = {min_tens, min_ones, sec_tens, sec_ones};

  always #5 clock = ~clock;

  countdown_timer_bcd #(.CLK_PER_SEC(4)) dut (
    .clock(clock), .resetn(resetn), .clearn(clearn), .load(load),
    .load_value(load_value), .mag_on(mag_on),
`ifdef TIMER_ADD30_EN
    .add30(add30),
`endif
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .timer_done(timer_done)
  );

  // Advance n rising edges; inputs are changed and outputs sampled 1 ns after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    load_value = v;
    step(1);
    load = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; clearn = 1'b1; load = 1'b0; load_value = '0; mag_on = 1'b0;
`ifdef TIMER_ADD30_EN
    add30 = 1'b0;
`endif
    step(2);
    checks++;
    if (mmss !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h want 0000", mmss); end
    checks++;
    if (timer_done !== 1'b1) begin errors++; $display("FAIL reset_done got %b want 1", timer_done); end
    resetn = 1'b1;
    step(1);
    do_load(16'h0130);
    checks++;
    if (mmss !== 16'h0130) begin errors++; $display("FAIL load_0130 got %h want 0130", mmss); end
    checks++;
    if (timer_done !== 1'b0) begin errors++; $display("FAIL load_0130_done got %b want 0", timer_done); end
    clearn = 1'b0;
    step(1);
    clearn = 1'b1;
    checks++;
    if (mmss !== 16'h0000 || timer_done !== 1'b1) begin
      errors++; $display("FAIL clear got %h/%b want 0000/1", mmss, timer_done);
    end
  endtask

  task automatic test_borrow_terminal;
    mag_on = 1'b1;
    do_load(16'h1000);
    step(3);
    checks++;
    if (mmss !== 16'h1000) begin errors++; $display("FAIL before_tick got %h want 1000", mmss); end
    step(1);
    checks++;
    if (mmss !== 16'h0959) begin errors++; $display("FAIL borrow_chain got %h want 0959", mmss); end
    do_load(16'h0002);
    step(4);
    checks++;
    if (mmss !== 16'h0001 || timer_done !== 1'b0) begin
      errors++; $display("FAIL count_0001 got %h/%b want 0001/0", mmss, timer_done);
    end
    step(4);
    checks++;
    if (mmss !== 16'h0000 || timer_done !== 1'b1) begin
      errors++; $display("FAIL terminal got %h/%b want 0000/1", mmss, timer_done);
    end
    step(20);
    checks++;
    if (mmss !== 16'h0000 || timer_done !== 1'b1) begin
      errors++; $display("FAIL no_wrap got %h/%b want 0000/1", mmss, timer_done);
    end
    mag_on = 1'b0;
  endtask

  task automatic test_pause_resume;
    do_load(16'h0005);
    mag_on = 1'b1;
    step(2);
    mag_on = 1'b0;
    step(10);
    checks++;
    if (mmss !== 16'h0005 || timer_done !== 1'b0) begin
      errors++; $display("FAIL paused got %h/%b want 0005/0", mmss, timer_done);
    end
    mag_on = 1'b1;
    step(1);
    checks++;
    if (mmss !== 16'h0005) begin errors++; $display("FAIL resume_early got %h want 0005", mmss); end
    step(1);
    checks++;
    if (mmss !== 16'h0004) begin errors++; $display("FAIL resume_tick got %h want 0004", mmss); end
    mag_on = 1'b0;
  endtask

  task automatic test_sanitise_priority;
    do_load(16'h1A7C);
    checks++;
    if (mmss !== 16'h1959) begin errors++; $display("FAIL sanitise got %h want 1959", mmss); end
    clearn = 1'b0;
    do_load(16'h0130);
    clearn = 1'b1;
    checks++;
    if (mmss !== 16'h0000 || timer_done !== 1'b1) begin
      errors++; $display("FAIL clear_over_load got %h/%b want 0000/1", mmss, timer_done);
    end
    do_load(16'h0009);
    mag_on = 1'b1;
    step(3);
    checks++;
    if (mmss !== 16'h0009) begin errors++; $display("FAIL pre_tick got %h want 0009", mmss); end
    do_load(16'h0007);
    checks++;
    if (mmss !== 16'h0007) begin errors++; $display("FAIL load_over_tick got %h want 0007", mmss); end
    step(4);
    checks++;
    if (mmss !== 16'h0006) begin errors++; $display("FAIL after_load_tick got %h want 0006", mmss); end
    mag_on = 1'b0;
  endtask

  task automatic test_async_reset;
    do_load(16'h0500);
    mag_on = 1'b1;
    step(6);
    checks++;
    if (mmss !== 16'h0459) begin errors++; $display("FAIL pre_reset got %h want 0459", mmss); end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (mmss !== 16'h0000 || timer_done !== 1'b1) begin
      errors++; $display("FAIL async_reset got %h/%b want 0000/1", mmss, timer_done);
    end
    mag_on = 1'b0;
    step(1);
    resetn = 1'b1;
    step(1);
  endtask

`ifdef TIMER_ADD30_EN
  task automatic test_add30;
    logic [15:0] start_v [3] = '{16'h0045, 16'h9940, 16'h0000};
    logic [15:0] want_v  [3] = '{16'h0115, 16'h9959, 16'h0030};
    for (int i = 0; i < 3; i++) begin
      do_load(start_v[i]);
      add30 = 1'b1;
      step(1);
      add30 = 1'b0;
      checks++;
      if (mmss !== want_v[i] || timer_done !== 1'b0) begin
        errors++; $display("FAIL add30_%0d got %h/%b want %h/0", i, mmss, timer_done, want_v[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_borrow_terminal();
    test_pause_resume();
    test_sanitise_priority();
    test_async_reset();
`ifdef TIMER_ADD30_EN
    test_add30();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
